// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the KCP53K two-master Wishbone arbiter.
package bus_arbiter_pkg;

   localparam int unsigned ADR_W       = 64;
   localparam int unsigned DAT_W       = 16;
   localparam int unsigned SEL_W       = 2;
   localparam int unsigned DEF_MAX_OUT = 4;

   // One-hot ownership encoding; the values are visible on gnt_o.
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_I    = 2'b01,
      GNT_D    = 2'b10
   } gnt_e;

   // Request payload forwarded from the owning master to the external port.
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
      logic             we;
      logic [SEL_W-1:0] sel;
   } wb_req_t;

   // Width of a counter that must hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Pipelined Wishbone port bundle; rd_slave is the read-only view used by fetch.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic [ADR_W-1:0] adr;
   logic [DAT_W-1:0] dat_w;
   logic [DAT_W-1:0] dat_r;
   logic             we;
   logic             stb;
   logic [SEL_W-1:0] sel;
   logic             ack;
   logic             stall;

   modport master   (output adr, dat_w, we, stb, sel, input  dat_r, ack, stall);
   modport slave    (input  adr, dat_w, we, stb, sel, output dat_r, ack, stall);
   modport rd_slave (input  adr, stb, sel,             output dat_r, ack, stall);
endinterface

// File: rtl/bus_arbiter_outstanding.sv
// Outstanding-beat tracker: counter, full flag, ack qualifier and sticky spurious-ack error.
module arb_outstanding
   import bus_arbiter_pkg::*;
#(
   parameter  int unsigned MAX_OUT = DEF_MAX_OUT,
   localparam int unsigned CNT_W   = cnt_width(MAX_OUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic beat,
   input  logic ack_in,
   output logic full,
   output logic ack_fwd,
   output logic drain_next,
   output logic err
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // An ack is only meaningful while something is outstanding.
   assign ack_fwd    = ack_in && (cnt != '0);
   assign full       = (cnt == CNT_W'(MAX_OUT));
   assign drain_next = (cnt_next == '0);

   // Next count: beats add, forwarded acks subtract, both together cancel.
   always_comb begin
      cnt_next = cnt;
      unique case ({beat, ack_fwd})
         2'b10:   cnt_next = cnt + CNT_W'(1);
         2'b01:   cnt_next = cnt - CNT_W'(1);
         default: cnt_next = cnt;
      endcase
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_next;
         if (ack_in && (cnt == '0))
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (I fetch, D load/store) to one-slave pipelined Wishbone arbiter.
// Optional macro KCP53K_ARB_RR_EN: round-robin tie-break instead of D-over-I.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   bus_arbiter_if.rd_slave        ibus,
   bus_arbiter_if.slave           dbus,
   bus_arbiter_if.master          mbus,
   output logic [1:0]             gnt_o,
   output logic                   err_o
);

   gnt_e    gnt_q;
   gnt_e    gnt_d;
   gnt_e    owner;
   wb_req_t req;
   logic    owner_stb;
   logic    cur_stb;
   logic    arb;
   logic    beat;
   logic    full;
   logic    ack_fwd;
   logic    drain_next;

`ifdef KCP53K_ARB_RR_EN
   gnt_e    last_q;
   gnt_e    last_d;
`endif

   arb_outstanding #(
      .MAX_OUT (MAX_OUT)
   ) u_outstanding (
      .clk        (clk_i),
      .reset      (reset_i),
      .beat       (beat),
      .ack_in     (mbus.ack),
      .full       (full),
      .ack_fwd    (ack_fwd),
      .drain_next (drain_next),
      .err        (err_o)
   );

   assign beat  = mbus.stb && !mbus.stall;
   assign gnt_o = gnt_q;

   // Grant state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         gnt_q  <= GNT_NONE;
`ifdef KCP53K_ARB_RR_EN
         last_q <= GNT_I;
`endif
      end else begin
         gnt_q  <= gnt_d;
`ifdef KCP53K_ARB_RR_EN
         last_q <= last_d;
`endif
      end
   end

   // Next owner: re-arbitrate when idle or when the owner has released and drained.
   always_comb begin
      gnt_d   = gnt_q;
      cur_stb = 1'b0;
`ifdef KCP53K_ARB_RR_EN
      last_d  = last_q;
`endif
      case (gnt_q)
         GNT_I:   cur_stb = ibus.stb;
         GNT_D:   cur_stb = dbus.stb;
         default: cur_stb = 1'b0;
      endcase
      arb = (gnt_q == GNT_NONE) || (!cur_stb && drain_next);
      if (arb) begin
         if (dbus.stb && ibus.stb) begin
`ifdef KCP53K_ARB_RR_EN
            gnt_d = (last_q == GNT_D) ? GNT_I : GNT_D;
`else
            gnt_d = GNT_D;
`endif
         end else if (dbus.stb) begin
            gnt_d = GNT_D;
         end else if (ibus.stb) begin
            gnt_d = GNT_I;
         end else begin
            gnt_d = GNT_NONE;
         end
`ifdef KCP53K_ARB_RR_EN
         if (gnt_d != GNT_NONE)
            last_d = gnt_d;
`endif
      end
   end

   // Combinational routing between the owner and the external port; idle while in reset.
   always_comb begin
      owner      = reset_i ? GNT_NONE : gnt_q;
      req        = '0;
      owner_stb  = 1'b0;
      ibus.stall = 1'b1;
      ibus.ack   = 1'b0;
      dbus.stall = 1'b1;
      dbus.ack   = 1'b0;
      ibus.dat_r = mbus.dat_r;
      dbus.dat_r = mbus.dat_r;
      case (owner)
         GNT_I: begin
            req.adr    = ibus.adr;
            req.sel    = ibus.sel;
            owner_stb  = ibus.stb;
            ibus.stall = mbus.stall || full;
            ibus.ack   = ack_fwd;
         end
         GNT_D: begin
            req.adr    = dbus.adr;
            req.dat    = dbus.dat_w;
            req.we     = dbus.we;
            req.sel    = dbus.sel;
            owner_stb  = dbus.stb;
            dbus.stall = mbus.stall || full;
            dbus.ack   = ack_fwd;
         end
         default: ;
      endcase
      mbus.adr   = req.adr;
      mbus.dat_w = req.dat;
      mbus.we    = req.we;
      mbus.sel   = req.sel;
      mbus.stb   = owner_stb && !full;
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (fixed-priority build, MAX_OUT = 4).
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset_i;
   logic [1:0] gnt_o;
   logic       err_o;
   int         total  = 0;
   int         passed = 0;
   int         failed = 0;

   bus_arbiter_if ibus ();
   bus_arbiter_if dbus ();
   bus_arbiter_if mbus ();

   bus_arbiter #(.MAX_OUT(4)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .ibus    (ibus),
      .dbus    (dbus),
      .mbus    (mbus),
      .gnt_o   (gnt_o),
      .err_o   (err_o)
   );

   always #5 clk = ~clk;

   // Move to 2 time units past the next rising edge, where inputs are changed.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_i     = 1'b1;
      ibus.adr    = '0;  ibus.stb = 1'b0; ibus.sel = '0;
      ibus.we     = 1'b0; ibus.dat_w = '0;
      dbus.adr    = '0;  dbus.stb = 1'b0; dbus.sel = '0;
      dbus.we     = 1'b0; dbus.dat_w = '0;
      mbus.ack    = 1'b0; mbus.stall = 1'b0; mbus.dat_r = '0;

      // Idle after one reset cycle
      tick();
      reset_i = 1'b0;
      #1;
      chk("rst_gnt",    64'(gnt_o),      64'h0);
      chk("rst_istall", 64'(ibus.stall), 64'h1);
      chk("rst_dstall", 64'(dbus.stall), 64'h1);
      chk("rst_mstb",   64'(mbus.stb),   64'h0);
      chk("rst_err",    64'(err_o),      64'h0);

      // I-side single read at 0x1000
      ibus.adr = 64'h1000; ibus.sel = 2'b11; ibus.stb = 1'b1;
      #1;
      chk("i_pre_gnt",  64'(gnt_o),      64'h0);
      chk("i_pre_mstb", 64'(mbus.stb),   64'h0);
      tick();
      #1;
      chk("i_gnt",      64'(gnt_o),      64'h1);
      chk("i_madr",     mbus.adr,        64'h1000);
      chk("i_mwe",      64'(mbus.we),    64'h0);
      chk("i_mstb",     64'(mbus.stb),   64'h1);
      chk("i_istall",   64'(ibus.stall), 64'h0);
      tick();
      ibus.stb = 1'b0; mbus.ack = 1'b1; mbus.dat_r = 16'hBEEF;
      #1;
      chk("i_iack",     64'(ibus.ack),   64'h1);
      chk("i_dack",     64'(dbus.ack),   64'h0);
      chk("i_idat",     64'(ibus.dat_r), 64'hBEEF);
      tick();
      mbus.ack = 1'b0;
      #1;
      chk("i_release",  64'(gnt_o),      64'h0);
      chk("i_err",      64'(err_o),      64'h0);

      // Simultaneous strobes: D wins; I keeps strobing for the later handover
      ibus.adr = 64'h3000; ibus.stb = 1'b1;
      dbus.adr = 64'h2000; dbus.we = 1'b1; dbus.dat_w = 16'h1234; dbus.sel = 2'b01;
      dbus.stb = 1'b1;
      tick();
      #1;
      chk("tie_gnt",    64'(gnt_o),      64'h2);
      chk("tie_madr",   mbus.adr,        64'h2000);
      chk("tie_mwe",    64'(mbus.we),    64'h1);
      chk("tie_mdat",   64'(mbus.dat_w), 64'h1234);
      chk("tie_msel",   64'(mbus.sel),   64'h1);
      chk("tie_istall", 64'(ibus.stall), 64'h1);
      chk("tie_dstall", 64'(dbus.stall), 64'h0);

      // Counter limit: slave never acks, D keeps strobing
      tick(); tick(); tick();
      #1;
      chk("lim3_dstall", 64'(dbus.stall), 64'h0);
      chk("lim3_mstb",   64'(mbus.stb),   64'h1);
      tick();
      #1;
      chk("lim4_dstall", 64'(dbus.stall), 64'h1);
      chk("lim4_mstb",   64'(mbus.stb),   64'h0);
      tick();
      #1;
      chk("lim5_dstall", 64'(dbus.stall), 64'h1);
      chk("lim5_mstb",   64'(mbus.stb),   64'h0);
      chk("lim5_gnt",    64'(gnt_o),      64'h2);
      mbus.ack = 1'b1;
      #1;
      chk("lim_ack_dack", 64'(dbus.ack),  64'h1);
      chk("lim_ack_mstb", 64'(mbus.stb),  64'h0);
      tick();
      mbus.ack = 1'b0;
      #1;
      chk("lim_free_dstall", 64'(dbus.stall), 64'h0);
      chk("lim_free_mstb",   64'(mbus.stb),   64'h1);

      // Handover: D stops with 3 outstanding, drains, I takes over without idle
      dbus.stb = 1'b0; mbus.ack = 1'b1;
      #1;
      chk("ho_mstb", 64'(mbus.stb), 64'h0);
      tick();
      #1;
      chk("ho_gnt2", 64'(gnt_o), 64'h2);
      tick();
      #1;
      chk("ho_gnt1", 64'(gnt_o),    64'h2);
      chk("ho_dack", 64'(dbus.ack), 64'h1);
      tick();
      mbus.ack = 1'b0;
      #1;
      chk("ho_gnt_i",   64'(gnt_o),      64'h1);
      chk("ho_madr",    mbus.adr,        64'h3000);
      chk("ho_mwe",     64'(mbus.we),    64'h0);
      chk("ho_istall",  64'(ibus.stall), 64'h0);

      // Build up 3 outstanding I beats, then reset mid-transfer
      tick(); tick(); tick();
      #1;
      chk("pre_rst_gnt",    64'(gnt_o),      64'h1);
      chk("pre_rst_istall", 64'(ibus.stall), 64'h0);
      reset_i = 1'b1;
      #1;
      chk("in_rst_mstb",   64'(mbus.stb),   64'h0);
      chk("in_rst_istall", 64'(ibus.stall), 64'h1);
      tick();
      reset_i = 1'b0; ibus.stb = 1'b0;
      #1;
      chk("post_rst_gnt", 64'(gnt_o), 64'h0);
      chk("post_rst_err", 64'(err_o), 64'h0);

      // Spurious ack: regrant I, stall the slave, ack with nothing outstanding
      ibus.stb = 1'b1;
      tick();
      mbus.stall = 1'b1; mbus.ack = 1'b1;
      #1;
      chk("sp_gnt",    64'(gnt_o),      64'h1);
      chk("sp_iack",   64'(ibus.ack),   64'h0);
      chk("sp_istall", 64'(ibus.stall), 64'h1);
      tick();
      mbus.ack = 1'b0; ibus.stb = 1'b0; mbus.stall = 1'b0;
      #1;
      chk("sp_err",  64'(err_o), 64'h1);
      tick();
      #1;
      chk("sp_err_sticky", 64'(err_o), 64'h1);
      chk("sp_gnt_idle",   64'(gnt_o), 64'h0);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      chk("sp_err_clr", 64'(err_o), 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
